// File: rtl/sw_debouncer.sv
// Switch debouncer: 2-flop synchronizer + 4-state qualify FSM.
// Ports: Clk, Reset (sync, high), D_raw in; Q, Rise, Fall, Busy out.
module sw_debouncer #(
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D_raw,
  output logic Q,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    WAIT1   = 2'd1,
    STABLE1 = 2'd2,
    WAIT0   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CNT_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= STABLE0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    s1_d    = D_raw;
    s2_d    = s1_q;
    unique case (state_q)
      STABLE0: begin
        if (s2_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s2_q) begin
          // bounce: drop the partial count
          state_d = STABLE0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE1;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE1: begin
        if (!s2_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s2_q) begin
          state_d = STABLE1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE0;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE0;
        cnt_d   = '0;
      end
    endcase
    // outputs registered from the next state so they line up with it
    q_d    = (state_d == STABLE1) || (state_d == WAIT0);
    busy_d = (state_d == WAIT1) || (state_d == WAIT0);
  end

  assign Q    = q_q;
  assign Rise = rise_q;
  assign Fall = fall_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with CNT_MAX=4, CNT_W=3.
// Edge numbers are counted from the edge where s1 first sees a new level.
module tb_sw_debouncer;

  logic Clk;
  logic Reset;
  logic D_raw;
  logic Q;
  logic Rise;
  logic Fall;
  logic Busy;

  int n_chk;
  int n_err;

  sw_debouncer #(
    .CNT_MAX(4),
    .CNT_W  (3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .D_raw(D_raw),
    .Q    (Q),
    .Rise (Rise),
    .Fall (Fall),
    .Busy (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {Q, Rise, Fall, Busy};
  endfunction

  // clean transition to lvl; checks edges 0..7
  task automatic qualify(input string tag, input logic lvl);
    logic [3:0] e;
    D_raw = lvl;
    for (int i = 0; i < 8; i++) begin
      tick();
      e[3] = (i >= 6) ? lvl : ~lvl;
      e[2] = (i == 6) && lvl;
      e[1] = (i == 6) && !lvl;
      e[0] = (i >= 2) && (i <= 5);
      check($sformatf("%s_e%0d", tag, i), outs(), e);
    end
  endtask

  initial begin
    logic [3:0] e;
    n_chk = 0;
    n_err = 0;
    Reset = 1'b1;
    D_raw = 1'b1;
    tick();
    tick();
    check("reset_outs", outs(), 4'b0000);
    check("reset_s2", {3'b0, dut.s2_q}, 4'b0000);
    D_raw = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check("idle", outs(), 4'b0000);

    // single-cycle glitch while Q=0
    D_raw = 1'b1;
    tick();
    D_raw = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick();
      e = {3'b000, (i == 2)};
      check($sformatf("glitch_e%0d", i), outs(), e);
    end

    // clean rise
    qualify("rise", 1'b1);
    // clean fall
    qualify("fall", 1'b0);

    // bounce: 1 x3, 0 x1, then 1 held
    D_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      D_raw = (i == 2) ? 1'b0 : 1'b1;
      e[3] = (i >= 10);
      e[2] = (i == 10);
      e[1] = 1'b0;
      e[0] = (i >= 2 && i <= 4) || (i >= 6 && i <= 9);
      check($sformatf("bounce_e%0d", i), outs(), e);
    end

    // back-to-back: fall right after settling high
    qualify("b2b_fall", 1'b0);
    qualify("b2b_rise", 1'b1);
    qualify("b2b_fall2", 1'b0);

    // reset mid-WAIT1 with counter at 2
    D_raw = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", outs(), 4'b0001);
    check("pre_rst_cnt", {1'b0, dut.cnt_q}, 4'd2);
    Reset = 1'b1;
    tick();
    check("mid_rst", outs(), 4'b0000);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      e[3] = (i >= 6);
      e[2] = (i == 6);
      e[1] = 1'b0;
      e[0] = (i >= 2) && (i <= 5);
      check($sformatf("post_rst_e%0d", i), outs(), e);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
